// File: rtl/prog_load_ctrl.sv
// Purpose : serial program/data loader and run controller for the tiny core.
// Latency : write strobe one cycle after the selected chip-select first reads high.
// Backpressure: none; the host paces frames and must leave two idle cycles between them.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   i_csi_n, i_csd_n   instruction / data memory frame selects (active low)
//   i_mosi             serial bit, sampled every clk while the selected select is low
//   i_run_req          host level request to run the core
//   i_core_halted      core reports its PC is frozen
//   i_err_clr          clears o_frame_err
//   o_imem_we/o_dmem_we one-cycle memory write strobes
//   o_mem_addr/o_mem_data write address/data (valid only with a strobe)
//   o_core_rst/o_core_run core held in reset / core enabled
//   o_done             registered copy of i_core_halted while running
//   o_busy             frame in progress or commit pending
//   o_frame_err        sticky frame/protocol error
//   o_frame_cnt        committed frame count, wraps
module prog_load_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_csi_n,
  input  logic              i_csd_n,
  input  logic              i_mosi,
  input  logic              i_run_req,
  input  logic              i_core_halted,
  input  logic              i_err_clr,
  output logic              o_imem_we,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_core_rst,
  output logic              o_core_run,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_frame_err,
  output logic [7:0]        o_frame_cnt
);

  localparam int FL = DATA_W + ADDR_W;
  localparam int CW = $clog2(FL + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FL);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FL + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT,
    S_RUN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [FL-1:0]   r_sr;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_tgt_d;      // 1: frame targets data memory
  logic            w_tgt_nxt;
  logic            w_shift;
  logic            w_err_set;
  logic            r_frame_err;
  logic [7:0]      r_frame_cnt;
  logic            r_done;
  logic            w_sel_lo;
  logic            w_oth_lo;

  // Select seen from the point of view of the frame currently being shifted.
  assign w_sel_lo = r_tgt_d ? ~i_csd_n : ~i_csi_n;
  assign w_oth_lo = r_tgt_d ? ~i_csi_n : ~i_csd_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_tgt_d     <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tgt_d <= w_tgt_nxt;
      if (w_shift) begin
        r_sr <= {r_sr[FL-2:0], i_mosi};
      end
      // A new error in the same cycle wins over a clear request.
      r_frame_err <= w_err_set | (r_frame_err & ~i_err_clr);
      if (r_state == S_COMMIT) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      // Leaving RUN clears done on the way into IDLE.
      r_done <= (r_state == S_RUN && i_run_req) ? i_core_halted : 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tgt_nxt   = r_tgt_d;
    w_shift     = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_csi_n && !i_csd_n) begin
          w_err_set = 1'b1;
        end else if (!i_csi_n || !i_csd_n) begin
          w_tgt_nxt   = ~i_csd_n;
          w_shift     = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_SHIFT;
        end else if (i_run_req) begin
          w_state_nxt = S_RUN;
        end
      end
      S_SHIFT: begin
        if (w_oth_lo) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_sel_lo) begin
          w_shift   = 1'b1;
          w_cnt_nxt = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CW'(1);
        end else if (r_cnt == CNT_FULL) begin
          w_state_nxt = S_COMMIT;
        end else begin
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_COMMIT: begin
        // The host violated the inter-frame gap; the bit is dropped but the write stands.
        if (!i_csi_n || !i_csd_n) begin
          w_err_set = 1'b1;
        end
        w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (!i_csi_n || !i_csd_n) begin
          w_err_set = 1'b1;
        end
        if (!i_run_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_imem_we   = (r_state == S_COMMIT) && !r_tgt_d;
  assign o_dmem_we   = (r_state == S_COMMIT) &&  r_tgt_d;
  assign o_mem_data  = r_sr[FL-1:ADDR_W];
  assign o_mem_addr  = r_sr[ADDR_W-1:0];
  assign o_core_rst  = (r_state != S_RUN);
  assign o_core_run  = (r_state == S_RUN);
  assign o_busy      = (r_state == S_SHIFT) || (r_state == S_COMMIT);
  assign o_done      = r_done;
  assign o_frame_err = r_frame_err;
  assign o_frame_cnt = r_frame_cnt;

endmodule
